ahb_dec12: RTL and testbench

AHB_DEC12 -- requirements
Module: ahb_dec12

---
 rtl/ahb_dec12.sv | 90 +++++++++
 tb/tb_ahb_dec12.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ahb_dec12.sv
// AHB address decoder for 11 mapped slaves plus a default slave (index 11)
// that answers unmapped NONSEQ/SEQ transfers with a two-cycle ERROR response.
module ahb_dec12 #(
  parameter int AW   = 32,
  parameter int RLSB = 28
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic [AW-1:0] HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HREADY,
  output logic [11:0]   hsel,
  output logic [11:0]   dsel,
  output logic          def_hreadyout,
  output logic          def_hresp,
  output logic [7:0]    err_cnt
);

  typedef enum logic [1:0] {
    S_OKAY = 2'd0,
    S_ERR1 = 2'd1,
    S_ERR2 = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] dsel_q, dsel_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [3:0]  region;
  logic        err_start;

  // Only the region field and HTRANS[1] matter; the rest is consumed here.
  logic unused_bits;
  assign unused_bits = ^{HADDR, HTRANS[0]};

  assign region = HADDR[RLSB+3:RLSB];

  always_comb begin
    hsel = '0;
    if (region > 4'd10) hsel[11] = 1'b1;
    else                hsel = 12'b1 << region;
  end

  always_comb begin
    dsel_d = dsel_q;
    if (HREADY) dsel_d = hsel;
  end

  // ERR1 is always followed by ERR2; ERR2 behaves like OKAY for the next
  // address phase so back-to-back errors skip the OKAY cycle.
  always_comb begin
    state_d   = state_q;
    err_start = 1'b0;
    case (state_q)
      S_ERR1: state_d = S_ERR2;
      default: begin
        if (HREADY) begin
          if (hsel[11] && HTRANS[1]) begin
            state_d   = S_ERR1;
            err_start = 1'b1;
          end else begin
            state_d = S_OKAY;
          end
        end
      end
    endcase
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_start && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= S_OKAY;
      dsel_q    <= 12'h800;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      dsel_q    <= dsel_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign dsel          = dsel_q;
  assign def_hreadyout = (state_q != S_ERR1);
  assign def_hresp     = (state_q != S_OKAY);
  assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_ahb_dec12.sv
// Bench for ahb_dec12: directed vector table, reset/saturation sequences, and
// randomized traffic checked against a transaction-level model.
module tb_ahb_dec12;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b1;
  logic [31:0] HADDR = '0;
  logic [1:0]  HTRANS = 2'b00;
  logic        HREADY = 1'b1;
  logic [11:0] hsel, dsel;
  logic        def_hreadyout, def_hresp;
  logic [7:0]  err_cnt;

  ahb_dec12 #(.AW(32), .RLSB(28)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
    .HREADY(HREADY), .hsel(hsel), .dsel(dsel),
    .def_hreadyout(def_hreadyout), .def_hresp(def_hresp), .err_cnt(err_cnt)
  );

  always #5 HCLK = ~HCLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: who owns the data phase, how many cycles of ERROR remain, error tally.
  int m_owner;
  int m_err_left;  // 2 = in first error cycle, 1 = in second, 0 = none
  int m_cnt;

  typedef struct {
    logic [31:0] a;
    logic [1:0]  t;
    logic        r;
    logic [11:0] hs;
    logic [11:0] ds;
    logic        rdy;
    logic        rsp;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int slave_of(input logic [31:0] a);
    int r;
    r = int'(a >> 28);
    return (r > 10) ? 11 : r;
  endfunction

  task automatic model_reset();
    m_owner = 11; m_err_left = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input logic [31:0] a, input logic [1:0] t, input logic r);
    if (m_err_left == 2) m_err_left = 1;
    else if (r) begin
      if (slave_of(a) == 11 && (t == 2'b10 || t == 2'b11)) begin
        m_err_left = 2;
        if (m_cnt < 255) m_cnt = m_cnt + 1;
      end else m_err_left = 0;
    end
    if (r) m_owner = slave_of(a);
  endtask

  // Drive one address phase, compare in the middle of the cycle, then clock.
  task automatic step(input vec_t v, input bit use_tbl);
    logic [11:0] one;
    HADDR = v.a; HTRANS = v.t; HREADY = v.r;
    @(negedge HCLK);
    if (use_tbl) begin
      chk("tbl_hsel", 32'(hsel), 32'(v.hs));
      chk("tbl_dsel", 32'(dsel), 32'(v.ds));
      chk("tbl_rdy",  32'(def_hreadyout), 32'(v.rdy));
      chk("tbl_resp", 32'(def_hresp), 32'(v.rsp));
      chk("tbl_cnt",  32'(err_cnt), 32'(v.cnt));
    end else begin
      one = 12'b1;
      chk("hsel", 32'(hsel), 32'(one << slave_of(v.a)));
      chk("dsel", 32'(dsel), 32'(one << m_owner));
      chk("rdy",  32'(def_hreadyout), (m_err_left == 2) ? 32'd0 : 32'd1);
      chk("resp", 32'(def_hresp), (m_err_left != 0) ? 32'd1 : 32'd0);
      chk("cnt",  32'(err_cnt), 32'(m_cnt));
    end
    @(posedge HCLK);
    model_edge(v.a, v.t, v.r);
    #1;
  endtask

  // HREADY as the response mux would present it.
  function automatic logic mux_ready(input bit other_ready);
    if (m_owner == 11) return (m_err_left != 2);
    return other_ready;
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_dsel"}, 32'(dsel), 32'h800);
    chk({tag, "_rdy"},  32'(def_hreadyout), 32'd1);
    chk({tag, "_resp"}, 32'(def_hresp), 32'd0);
    chk({tag, "_cnt"},  32'(err_cnt), 32'd0);
  endtask

  initial begin
    vec_t v;
    tbl[0]  = '{32'h0000_0000, 2'b00, 1'b1, 12'h001, 12'h800, 1'b1, 1'b0, 8'd0};
    tbl[1]  = '{32'h3000_0000, 2'b10, 1'b1, 12'h008, 12'h001, 1'b1, 1'b0, 8'd0};
    tbl[2]  = '{32'hA000_0004, 2'b10, 1'b1, 12'h400, 12'h008, 1'b1, 1'b0, 8'd0};
    tbl[3]  = '{32'hC000_0000, 2'b10, 1'b1, 12'h800, 12'h400, 1'b1, 1'b0, 8'd0};
    tbl[4]  = '{32'h0000_0000, 2'b00, 1'b0, 12'h001, 12'h800, 1'b0, 1'b1, 8'd1};
    tbl[5]  = '{32'h0000_0000, 2'b00, 1'b1, 12'h001, 12'h800, 1'b1, 1'b1, 8'd1};
    tbl[6]  = '{32'h2000_0000, 2'b10, 1'b1, 12'h004, 12'h001, 1'b1, 1'b0, 8'd1};
    tbl[7]  = '{32'hF000_0000, 2'b10, 1'b0, 12'h800, 12'h004, 1'b1, 1'b0, 8'd1};
    tbl[8]  = '{32'hF000_0000, 2'b10, 1'b0, 12'h800, 12'h004, 1'b1, 1'b0, 8'd1};
    tbl[9]  = '{32'hF000_0000, 2'b10, 1'b0, 12'h800, 12'h004, 1'b1, 1'b0, 8'd1};
    tbl[10] = '{32'hF000_0000, 2'b10, 1'b1, 12'h800, 12'h004, 1'b1, 1'b0, 8'd1};
    tbl[11] = '{32'hB000_0000, 2'b10, 1'b0, 12'h800, 12'h800, 1'b0, 1'b1, 8'd2};
    tbl[12] = '{32'hB000_0000, 2'b10, 1'b1, 12'h800, 12'h800, 1'b1, 1'b1, 8'd2};
    tbl[13] = '{32'hB000_0000, 2'b10, 1'b0, 12'h800, 12'h800, 1'b0, 1'b1, 8'd3};
    tbl[14] = '{32'hB000_0000, 2'b00, 1'b1, 12'h800, 12'h800, 1'b1, 1'b1, 8'd3};
    tbl[15] = '{32'h0000_0000, 2'b00, 1'b1, 12'h001, 12'h800, 1'b1, 1'b0, 8'd3};
    tbl[16] = '{32'hE000_0000, 2'b01, 1'b1, 12'h800, 12'h001, 1'b1, 1'b0, 8'd3};
    tbl[17] = '{32'h0000_0000, 2'b00, 1'b1, 12'h001, 12'h800, 1'b1, 1'b0, 8'd3};
    tbl[18] = '{32'h0000_0000, 2'b00, 1'b1, 12'h001, 12'h001, 1'b1, 1'b0, 8'd3};

    // Power-on reset, checked while still asserted.
    #1 HRESETn = 1'b0;
    model_reset();
    repeat (2) @(posedge HCLK);
    #2 check_reset_vals("por");
    @(posedge HCLK); #1 HRESETn = 1'b1;

    foreach (tbl[i]) step(tbl[i], 1'b1);

    // Reset asserted while the default slave is in its first ERROR cycle.
    v = '{32'hC000_0000, 2'b10, 1'b1, '0, '0, 1'b0, 1'b0, '0};
    step(v, 1'b0);
    #2 HRESETn = 1'b0;
    #1 check_reset_vals("rst_err1");
    model_reset();
    @(posedge HCLK); #1 HRESETn = 1'b1;
    v = '{32'h0000_0000, 2'b00, 1'b1, '0, '0, 1'b0, 1'b0, '0};
    step(v, 1'b0);
    step(v, 1'b0);

    // Back-to-back unmapped NONSEQ until the error counter pins at FF.
    for (int i = 0; i < 620; i++) begin
      v = '{32'hB000_0000, 2'b10, mux_ready(1'b1), '0, '0, 1'b0, 1'b0, '0};
      step(v, 1'b0);
    end
    chk("cnt_sat", 32'(err_cnt), 32'hFF);

    // Randomized traffic with occasional stalls from mapped slaves.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      a = $urandom;
      v.a = a;
      v.t = 2'($urandom_range(0, 3));
      v.r = mux_ready($urandom_range(0, 3) != 0);
      step(v, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
